// File: rtl/sos_req_scheduler.sv
// sos_req_scheduler
// Round-robin arbiter that shares one SOS LED pattern generator between
// four requesters. Rising edges on Req are latched into Pend; one pending
// requester at a time is granted, the generator gets a one-cycle start
// pulse, and the grant is held for the fixed pattern window. After an
// optional quiet gap the next pending requester is served.
//
// Parameters:
//   T500MS    - prescaler terminal count (one tick every T500MS+1 cycles)
//   SEQ_TICKS - busy window length in ticks (>= 40 for the 19.5 s pattern)
//   GAP_TICKS - quiet gap after each pattern in ticks (0 = no gap)
//
// Ports:
//   CLK    - clock
//   RST_n  - asynchronous active-low reset
//   Req    - request lines, a rising edge requests one pattern
//   Clr    - synchronous clear of all pending requests (not the active grant)
//   SOS_En - one-cycle start pulse to the pattern generator
//   Grant  - one-hot owner of the generator, held through the busy window
//   Ack    - one-cycle completion pulse to the requester just served
//   Pend   - latched requests not yet served
//   Busy   - high during the busy window and the following gap
`timescale 1ns/1ps
module sos_req_scheduler #(
  parameter logic [24:0] T500MS    = 25'd24_999_999,
  parameter logic [5:0]  SEQ_TICKS = 6'd40,
  parameter logic [5:0]  GAP_TICKS = 6'd2
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [3:0] Req,
  input  logic       Clr,
  output logic       SOS_En,
  output logic [3:0] Grant,
  output logic [3:0] Ack,
  output logic [3:0] Pend,
  output logic       Busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t      state;
  logic [24:0] presc;
  logic [5:0]  ticks;
  logic [3:0]  req_q;
  logic [1:0]  last;

  logic [3:0]  rise;
  logic        tick;
  logic        found;
  logic [1:0]  sel;
  logic [1:0]  idx;
  logic [3:0]  sel_oh;
  logic [3:0]  pend_next;

  assign rise = Req & ~req_q;
  assign tick = (presc == T500MS);

  // Round-robin pick: first pending bit searching upward from last+1,
  // wrapping; the 2-bit add provides the mod-4 wrap.
  always_comb begin
    found = 1'b0;
    sel   = last;
    idx   = last;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last + i[1:0];
      if (!found && Pend[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    sel_oh = 4'b0001 << sel;
  end

  // Pending set: grant clear and Clr first, then a new rise re-sets the bit,
  // so a rise always wins (this is what re-queues the granted requester).
  always_comb begin
    pend_next = Pend;
    if (state == S_IDLE && found) pend_next[sel] = 1'b0;
    if (Clr) pend_next = '0;
    pend_next = pend_next | rise;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state  <= S_IDLE;
      presc  <= '0;
      ticks  <= '0;
      req_q  <= '0;
      last   <= 2'd3;
      SOS_En <= 1'b0;
      Grant  <= '0;
      Ack    <= '0;
      Pend   <= '0;
      Busy   <= 1'b0;
    end else begin
      req_q  <= Req;
      Pend   <= pend_next;
      SOS_En <= 1'b0;
      Ack    <= '0;
      case (state)
        S_IDLE: begin
          presc <= '0;
          ticks <= '0;
          if (found) begin
            Grant  <= sel_oh;
            SOS_En <= 1'b1;
            last   <= sel;
            Busy   <= 1'b1;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (tick) begin
            presc <= '0;
            if (ticks == SEQ_TICKS - 6'd1) begin
              Ack   <= Grant;
              Grant <= '0;
              ticks <= '0;
              if (GAP_TICKS == 6'd0) begin
                Busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                state <= S_GAP;
              end
            end else begin
              ticks <= ticks + 6'd1;
            end
          end else begin
            presc <= presc + 25'd1;
          end
        end
        S_GAP: begin
          if (tick) begin
            presc <= '0;
            if (ticks == GAP_TICKS - 6'd1) begin
              ticks <= '0;
              Busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              ticks <= ticks + 6'd1;
            end
          end else begin
            presc <= presc + 25'd1;
          end
        end
        default: begin
          presc <= '0;
          ticks <= '0;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
